// File: rtl/led_gravity_display_if.sv
// Control and LED bundle between a master (board top / LED mux) and the
// gravity display engine.
interface led_gravity_display_if #(parameter int N_LEDS = 16);
  logic              run;
  logic [1:0]        mode;
  logic [N_LEDS-1:0] LED;
  logic              falling;
  logic              cycle_done;

  modport master (output run, mode, input LED, falling, cycle_done);
  modport slave  (input run, mode, output LED, falling, cycle_done);
endinterface

// File: rtl/led_gravity_display.sv
// Constant-gravity LED animation: normalised time t, distance t*t, top bits -> LED.
// Optional LED_TRAIL_EN keeps the previous position lit as a trail.
module led_gravity_display #(
  parameter int N_LEDS   = 16,
  parameter int TICK_DIV = 381,
  parameter int T_BITS   = 17
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  led_gravity_display_if.slave  bus
);
  localparam int IDX_BITS = $clog2(N_LEDS);
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam logic [T_BITS-1:0] T_MAX = '1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_FALL     = 2'd0,
    M_BOUNCE   = 2'd1,
    M_FREEZE   = 2'd2,
    M_FALL_ALT = 2'd3
  } mode_e;

  logic [DIV_W-1:0]    div;
  logic                tick;
  logic [T_BITS-1:0]   t;
  logic [IDX_BITS-1:0] tsq_hi;

  function automatic logic [N_LEDS-1:0] onehot(input logic [IDX_BITS-1:0] i);
    return N_LEDS'(1) << i;
  endfunction

  assign tick = bus.run && (div == DIV_LAST);

  // Pausing clears the divider so a resume always waits a full tick period.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)  div <= '0;
    else if (!tick && bus.run) div <= div + DIV_W'(1);
    else              div <= '0;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      t              <= '0;
      bus.falling    <= 1'b1;
      bus.cycle_done <= 1'b0;
    end else begin
      bus.cycle_done <= 1'b0;
      if (tick) begin
        case (mode_e'(bus.mode))
          M_FREEZE: begin
          end
          M_BOUNCE: begin
            if (bus.falling) begin
              if (t == T_MAX) begin
                t           <= T_MAX - T_BITS'(1);
                bus.falling <= 1'b0;
              end else begin
                t <= t + T_BITS'(1);
              end
            end else if (t == '0) begin
              t              <= T_BITS'(1);
              bus.falling    <= 1'b1;
              bus.cycle_done <= 1'b1;
            end else begin
              t <= t - T_BITS'(1);
            end
          end
          default: begin
            t              <= t + T_BITS'(1);
            bus.falling    <= 1'b1;
            bus.cycle_done <= (t == T_MAX);
          end
        endcase
      end
    end
  end

  // Full-width square; only its top IDX_BITS are ever consumed, so only those are kept.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) tsq_hi <= '0;
    else tsq_hi <= IDX_BITS'(({{T_BITS{1'b0}}, t} * {{T_BITS{1'b0}}, t}) >> (2*T_BITS - IDX_BITS));
  end

`ifdef LED_TRAIL_EN
  logic [IDX_BITS-1:0] cur_idx, prev_idx;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cur_idx  <= '0;
      prev_idx <= '0;
      bus.LED  <= N_LEDS'(1);
    end else if (tsq_hi != cur_idx) begin
      prev_idx <= cur_idx;
      cur_idx  <= tsq_hi;
      bus.LED  <= onehot(tsq_hi) | onehot(cur_idx);
    end else begin
      bus.LED  <= onehot(tsq_hi) | onehot(prev_idx);
    end
  end
`else
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) bus.LED <= N_LEDS'(1);
    else             bus.LED <= onehot(tsq_hi);
  end
`endif

endmodule

// File: tb/tb_led_gravity_display.sv
// Randomised run/mode stimulus against a tick-level model of the gravity display;
// expected outputs are queued per cycle and compared by an independent monitor.
module tb_led_gravity_display;
  localparam int NL = 4, TD = 4, TB = 4, IB = 2, TMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_gravity_display_if #(.N_LEDS(NL)) bus();

  led_gravity_display #(.N_LEDS(NL), .TICK_DIV(TD), .T_BITS(TB)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] led;
    logic          falling;
    logic          cd;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Reference state: divider count, time, square of the time, direction.
  int m_div, m_t, m_tsq;
  bit m_falling, m_cd;
  logic [NL-1:0] m_led;
`ifdef LED_TRAIL_EN
  int m_cur, m_prev;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_t = 0; m_tsq = 0; m_falling = 1'b1; m_cd = 1'b0; m_led = NL'(1);
`ifdef LED_TRAIL_EN
    m_cur = 0; m_prev = 0;
`endif
  endtask

  // Advance the model across one rising edge with inputs r/md and queue the outputs.
  task automatic drive_step(input bit r, input int md);
    bit tk;
    int idx;
    bus.run  = r;
    bus.mode = md[1:0];
    tk = r && (m_div == TD - 1);
    m_div = (r && !tk) ? m_div + 1 : 0;
    idx = m_tsq / (1 << (2*TB - IB));
`ifdef LED_TRAIL_EN
    if (idx != m_cur) begin m_prev = m_cur; m_cur = idx; end
    m_led = NL'(1 << m_cur) | NL'(1 << m_prev);
`else
    m_led = NL'(1 << idx);
`endif
    m_tsq = m_t * m_t;
    m_cd = 1'b0;
    if (tk) begin
      if (md == 1) begin
        if (m_falling && m_t == TMAX) begin m_t = TMAX - 1; m_falling = 1'b0; end
        else if (m_falling)           m_t = m_t + 1;
        else if (m_t == 0)            begin m_t = 1; m_falling = 1'b1; m_cd = 1'b1; end
        else                          m_t = m_t - 1;
      end else if (md != 2) begin
        m_cd = (m_t == TMAX);
        m_t = (m_t + 1) % (TMAX + 1);
        m_falling = 1'b1;
      end
    end
    q.push_back('{m_led, m_falling, m_cd});
  endtask

  task automatic cycle(input bit r, input int md);
    @(negedge clk);
    drive_step(r, md);
  endtask

  // Monitor: every queued expectation belongs to the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("led", int'(bus.LED), int'(e.led));
        chk("falling", int'(bus.falling), int'(e.falling));
        chk("cycle_done", int'(bus.cycle_done), int'(e.cd));
      end
    end
  end

  initial begin
    int n;
    bus.run = 1'b1;
    bus.mode = 2'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    chk("rst_led", int'(bus.LED), 1);
    chk("rst_falling", int'(bus.falling), 1);
    chk("rst_cycle_done", int'(bus.cycle_done), 0);

    @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b1, 0);

    // Full fall cycle including the wrap, then a full bounce period.
    repeat (80)  cycle(1'b1, 0);
    repeat (300) cycle(1'b1, 1);
    repeat (50)  cycle(1'b1, 2);

    for (int seg = 0; seg < 50; seg++) begin
      int md, len;
      md  = int'($urandom_range(0, 3));
      len = int'($urandom_range(20, 150));
      for (int i = 0; i < len; i++) cycle($urandom_range(0, 9) != 0, md);
    end

    // Steer into descending bounce at t=9, then hit async reset between edges.
    n = 0;
    while (!(m_t == 9 && !m_falling) && n < 400) begin
      cycle(1'b1, 1);
      n++;
    end
    if (n >= 400) begin
      chk("reach_t9_timeout", n, 0);
    end else begin
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_led", int'(bus.LED), 1);
      chk("async_falling", int'(bus.falling), 1);
      chk("async_cycle_done", int'(bus.cycle_done), 0);
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive_step(1'b1, 0);
    end

    for (int i = 0; i < 200; i++) cycle($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)));

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_gravity_display.md
# led_gravity_display

Parametrised LED animation engine for the Nexys4DDR LED bar: models a body under constant gravity (distance proportional to t²) and maps the normalised distance onto a one-hot LED position. It generalises the single-mode 16-LED waterfall to configurable LED count, time base and time resolution. It adds run control, a ping-pong (bounce) mode, a freeze mode, and a cycle-complete pulse. It sits directly between the board clock and the LED pins, or under a top-level that multiplexes LED sources.

## Interface
- `N_LEDS`, 16: LED count; power of two, 2..64; `IDX_BITS = log2(N_LEDS)`.
- `TICK_DIV`, 381: clock cycles per time-base tick; ≥2.
- `T_BITS`, 17: width of normalised time `t` (unsigned fraction, 0 ≤ t < 1); ≥ `IDX_BITS`.
- `CLK100MHZ`  in  1  board clock; all state on rising edge.
- `CPU_RESETN`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = animate; 0 = pause (divider cleared, `t` held).
- `mode`  in  2  0 FALL, 1 BOUNCE, 2 FREEZE, 3 treated as FALL.
- `LED`  out  N_LEDS  LED drive, registered.
- `falling`  out  1  1 while `t` increments; registered.
- `cycle_done`  out  1  one-cycle pulse at animation cycle end; registered.

## Operation
- Divider: counter `div` 0..TICK_DIV-1, increments only when `run`=1. `tick`=1 when `run`=1 and `div`=TICK_DIV-1, and `div` then wraps to 0. `run`=0 forces `div` to 0 next cycle.
- `mode` is sampled only on cycles with `tick`=1.
- FALL: `t` ← `t`+1 per tick, wraps max→0. `falling` forced 1. `cycle_done` pulses on the wrap tick.
- BOUNCE: ascending while `falling`=1. At `t`=max the next tick sets `t`=max-1 and `falling`=0. Descending, at `t`=0 the next tick sets `t`=1, `falling`=1 and pulses `cycle_done`. Each endpoint value is held exactly one tick; period = 2·(2^T_BITS − 1) ticks.
- FREEZE: `t`, `falling` held; no `cycle_done`.
- Mode change FALL→BOUNCE continues ascending from current `t`. BOUNCE→FALL with `falling`=0 sets `falling`=1 and increments from current `t` (no jump).
- Arithmetic: `tsq` = `t`·`t`, full 2·T_BITS bits, unsigned, no truncation before the index. `idx` = `tsq[2·T_BITS-1 -: IDX_BITS]`.
- `LED` = one-hot(`idx`) (only `LED[idx]`=1), unless the trail feature below is compiled in.
- Reset (async assert, any state): `div`=0, `t`=0, `tsq`=0, `falling`=1, `cycle_done`=0, `LED`=1 (LED[0] on). Deassertion is synchronous to clock use; the first tick occurs TICK_DIV cycles after the first cycle with `run`=1.

## Timing
- `t`, `falling` update on the edge where `tick`=1. `cycle_done` asserts for exactly the cycle after that edge.
- `tsq` registered one cycle after `t` (DSP M register); `LED` registered one cycle after `tsq`. `t` change → `LED` change latency = 2 clocks.
- `cycle_done` is not pipeline-aligned to `LED`: it leads the LED update by 2 cycles.
- Tick period = TICK_DIV clocks exactly; full fall time = TICK_DIV·2^T_BITS clocks (defaults ≈ 0.5 s).

## Configuration
- `LED_TRAIL_EN` defined: an extra register `prev_idx` (reset 0) captures the old `idx` whenever `idx` changes. `LED` = one-hot(`idx`) | one-hot(`prev_idx`), so two LEDs are lit after the first move and one while `idx` = `prev_idx`. Same latency.
- Not defined: no `prev_idx`; `LED` strictly one-hot.

## Test plan
Bench parameters: N_LEDS=4, TICK_DIV=4, T_BITS=4 unless noted.
- Reset with `run`=1, mode 0 → `LED`=4'b0001, `falling`=1, `cycle_done`=0 during reset. First `t` increment occurs 4 clocks after release.
- FALL, run 16 ticks → `t` 8 gives `LED`=0010, `t`=12 gives 0100, `t`=15 gives 1000 (2 clocks after each `t` change). Wrap 15→0 pulses `cycle_done` for 1 clock, then `LED`=0001.
- BOUNCE → `t` sequence 14,15,14,…,1,0,1. `falling` drops on the 15→14 tick. `cycle_done` pulses only on the 0→1 tick; period 30 ticks.
- `run`=0 mid-count with `div`=2 → `t`, `LED` frozen, `div`=0 next cycle. On `run`=1 the next tick occurs 4 clocks later. Mode 2 with `run`=1 → `t` constant over 10 ticks.
- Async reset asserted mid-BOUNCE with `falling`=0, `t`=9 → immediately `t`=0, `LED`=0001, `falling`=1, with no clock edge needed.
- With `LED_TRAIL_EN`, FALL at t 7→8 → `LED`=0011. Then at t 11→12 → 0110. Without the macro → 0010, 0100.
